core_run_ctrl: RTL and testbench

Run sequencer for the single-cycle RISC-V core (arch2).
- Holds the core in reset, releases it on a start pulse, and counts executed cycles.
- Captures the value the program stores to a fixed result address, and detects program end from a self-loop halt (`j .`).
- Sits between the bench/top level and the core; it drives the core's reset and observes PC and the data-memory write port.
- Ends each run as either done or timed out, then freezes the core.

---
 rtl/core_ctrl_pkg.sv | 16 +
 rtl/core_run_ctrl.sv | 95 +++++++++
 tb/tb_core_run_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared encodings and defaults for the core run sequencer.
// State values are fixed so external checkers can decode them directly.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  localparam logic [31:0] DEF_RESULT_ADDR = 32'h0000_0040;
  localparam int          DEF_MAX_CYCLES  = 1000;

endpackage

// File: rtl/core_run_ctrl.sv
// Run sequencer for the single-cycle core: holds it in reset, releases it on start,
// counts run cycles, captures the result store and ends on halt (j .) or timeout.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int          RST_CYCLES  = 2,
  parameter logic [31:0] RESULT_ADDR = DEF_RESULT_ADDR,
  parameter int          MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      core_pc,
  input  logic             core_mem_we,
  input  logic [31:0]      core_mem_addr,
  input  logic [31:0]      core_mem_wdata,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      result,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int               HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [31:0]       pc_prev_q;
  logic              pc_valid_q;
  logic [31:0]       result_q;
  logic [CNT_W-1:0]  cnt_q;

  logic halt;
  logic result_hit;
  logic can_launch;

  // A halt is the core fetching the same PC on two consecutive run cycles.
  assign halt       = pc_valid_q && (core_pc == pc_prev_q);
  assign result_hit = core_mem_we && (core_mem_addr == RESULT_ADDR);
  assign can_launch = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                      (state_q == ST_TIMEOUT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: if (start) state_d = ST_HOLD;
      ST_HOLD:                      if (hold_q == HOLD_LAST) state_d = ST_RUN;
      ST_RUN: begin
        if (halt)                    state_d = ST_DONE;
        else if (cnt_q == CNT_LAST)  state_d = ST_TIMEOUT;
      end
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      pc_prev_q  <= '0;
      pc_valid_q <= 1'b0;
      result_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (can_launch && start) begin
        hold_q     <= '0;
        cnt_q      <= '0;
        result_q   <= '0;
        pc_valid_q <= 1'b0;
      end else if (state_q == ST_HOLD) begin
        hold_q <= hold_q + 1'b1;
      end else if (state_q == ST_RUN) begin
        // The final (halt or timeout) edge still counts and still captures.
        cnt_q      <= cnt_q + 1'b1;
        pc_prev_q  <= core_pc;
        pc_valid_q <= 1'b1;
        if (result_hit) result_q <= core_mem_wdata;
      end
    end
  end

  // Decoded from the state register so reset forces core_rst high immediately.
  assign core_rst    = (state_q != ST_RUN);
  assign busy        = (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign timeout     = (state_q == ST_TIMEOUT);
  assign result      = result_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: scripted and random core traces checked against a
// trace-level model of when the run ends, how long it took and what it stored.
module tb_core_run_ctrl;

  localparam int          RST_N  = 2;
  localparam int          MAX_N  = 20;
  localparam logic [31:0] RADDR  = 32'h0000_0040;
  localparam int          CW     = 16;
  localparam int          TR_LEN = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   core_pc;
  logic          core_mem_we;
  logic [31:0]   core_mem_addr;
  logic [31:0]   core_mem_wdata;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [31:0]   result;
  logic [CW-1:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run-cycle trace of what the core presents; index = run cycle number.
  logic [31:0] pc_tr   [TR_LEN];
  logic        we_tr   [TR_LEN];
  logic [31:0] addr_tr [TR_LEN];
  logic [31:0] data_tr [TR_LEN];

  core_run_ctrl #(
    .RST_CYCLES (RST_N),
    .RESULT_ADDR(RADDR),
    .MAX_CYCLES (MAX_N),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .core_pc       (core_pc),
    .core_mem_we   (core_mem_we),
    .core_mem_addr (core_mem_addr),
    .core_mem_wdata(core_mem_wdata),
    .core_rst      (core_rst),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .result        (result),
    .cycle_count   (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Straight-line code whose self-loop is fetched first at cycle h-1;
  // the repeated PC is seen at cycle h (h >= TR_LEN means no halt at all).
  task automatic build_linear(input int h);
    for (int k = 0; k < TR_LEN; k++) begin
      pc_tr[k]   = (k < h) ? 32'(4 * k) : 32'(4 * (h - 1));
      we_tr[k]   = 1'b0;
      addr_tr[k] = 32'h0;
      data_tr[k] = 32'h0;
    end
  endtask

  task automatic add_store(input int k, input logic [31:0] a, input logic [31:0] d);
    we_tr[k]   = 1'b1;
    addr_tr[k] = a;
    data_tr[k] = d;
  endtask

  // Value the program has stored at RADDR over cycles 0..upto-1.
  function automatic logic [31:0] last_store(input int upto);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < upto; k++)
      if (we_tr[k] && addr_tr[k] == RADDR) v = data_tr[k];
    return v;
  endfunction

  task automatic drive_idle_core();
    core_pc        = 32'h0;
    core_mem_we    = 1'b0;
    core_mem_addr  = 32'h0;
    core_mem_wdata = 32'h0;
  endtask

  // Runs the current trace. noisy adds start pulses in HOLD and RUN;
  // abort_k >= 0 asserts reset between edges during run cycle abort_k.
  task automatic run_prog(input string nm, input bit noisy, input int abort_k);
    int  hc, k, end_k, exp_cnt;
    bit  exp_done;

    exp_done = 1'b0;
    end_k    = MAX_N - 1;
    exp_cnt  = MAX_N;
    for (int j = 1; j < MAX_N; j++) begin
      if (!exp_done && pc_tr[j] == pc_tr[j-1]) begin
        exp_done = 1'b1;
        end_k    = j;
        exp_cnt  = j + 1;
      end
    end

    @(negedge clk);
    drive_idle_core();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hc = 0;
    while (core_rst && hc < 20) begin
      hc++;
      start = noisy && (hc == 1);
      @(negedge clk);
      start = 1'b0;
    end
    check({nm, "_hold_len"}, 32'(hc), 32'(RST_N));

    k = 0;
    while (!done && !timeout && k < TR_LEN) begin
      check({nm, "_run_cnt"}, 32'(cycle_count), 32'(k));
      check({nm, "_run_res"}, result, last_store(k));
      check({nm, "_run_busy"}, {30'h0, busy, core_rst}, 32'h2);
      core_pc        = pc_tr[k];
      core_mem_we    = we_tr[k];
      core_mem_addr  = addr_tr[k];
      core_mem_wdata = data_tr[k];
      start          = noisy && (k == 3);
      if (k == abort_k) begin
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check({nm, "_abort_rst_busy"}, {30'h0, core_rst, busy}, 32'h2);
        check({nm, "_abort_res"}, result, 32'h0);
        check({nm, "_abort_cnt"}, 32'(cycle_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        drive_idle_core();
        @(negedge clk);
        check({nm, "_post_flags"}, {28'h0, core_rst, busy, done, timeout}, 32'h8);
        check({nm, "_post_res"}, result, 32'h0);
        check({nm, "_post_cnt"}, 32'(cycle_count), 32'h0);
        return;
      end
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    if (k >= TR_LEN) check({nm, "_end_bound"}, 32'(k), 32'(end_k + 1));
    drive_idle_core();

    check({nm, "_done"}, {31'h0, done}, {31'h0, exp_done});
    check({nm, "_timeout"}, {31'h0, timeout}, {31'h0, !exp_done});
    check({nm, "_cnt"}, 32'(cycle_count), 32'(exp_cnt));
    check({nm, "_res"}, result, last_store(end_k + 1));
    check({nm, "_end_rst_busy"}, {30'h0, core_rst, busy}, 32'h2);
    // Frozen after the end: one more cycle changes nothing.
    @(negedge clk);
    check({nm, "_frozen_cnt"}, 32'(cycle_count), 32'(exp_cnt));
    check({nm, "_frozen_res"}, result, last_store(end_k + 1));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    drive_idle_core();
    #1;
    check("rst_flags", {28'h0, core_rst, busy, done, timeout}, 32'h8);
    check("rst_res", result, 32'h0);
    check("rst_cnt", 32'(cycle_count), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("idle_flags", {28'h0, core_rst, busy, done, timeout}, 32'h8);

    // Store 55 to 0x40 at PC 0x20, self-loop at 0x24.
    build_linear(10);
    add_store(8, 32'h40, 32'd55);
    run_prog("t1", 1'b0, -1);
    check("t1_const_cnt", 32'(cycle_count), 32'd11);
    check("t1_const_res", result, 32'd55);

    build_linear(TR_LEN);
    run_prog("t2_timeout", 1'b0, -1);
    check("t2_const_cnt", 32'(cycle_count), 32'd20);

    build_linear(MAX_N - 1);
    run_prog("t3_halt_at_limit", 1'b0, -1);
    check("t3_const_done", {30'h0, done, timeout}, 32'h2);

    build_linear(12);
    add_store(2, 32'h40, 32'd3);
    add_store(4, 32'h44, 32'd9);
    add_store(6, 32'h40, 32'd21);
    add_store(8, 32'h41, 32'd77);
    run_prog("t4_stores", 1'b0, -1);
    check("t4_const_res", result, 32'd21);

    build_linear(10);
    add_store(8, 32'h40, 32'd55);
    run_prog("t5_noisy", 1'b1, -1);
    run_prog("t5_rerun", 1'b0, -1);

    build_linear(TR_LEN);
    add_store(1, 32'h40, 32'd5);
    run_prog("t6_abort", 1'b0, 4);

    for (int it = 0; it < 30; it++) begin
      build_linear($urandom_range(1, 26));
      for (int k = 0; k < TR_LEN; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0:       add_store(k, 32'h40, $urandom);
            1:       add_store(k, 32'h44, $urandom);
            2:       add_store(k, 32'h41, $urandom);
            default: add_store(k, $urandom, $urandom);
          endcase
        end
      end
      run_prog($sformatf("rnd%0d", it), ($urandom_range(0, 3) == 0), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
